// File: rtl/sdram_burst_master.sv
// Burst initiator for the SDRAM controller user ports: arbitrates write/read FIFO service,
// issues full-length bursts, steers FIFO strobes from the acks and walks circular address windows.
module sdram_burst_master #(
  parameter int          DATA_W        = 16,
  parameter logic [9:0]  WR_BURST      = 10'd256,
  parameter logic [9:0]  RD_BURST      = 10'd256,
  parameter logic [23:0] WR_MIN_ADDR   = 24'd0,
  parameter logic [23:0] WR_MAX_ADDR   = 24'd768000,
  parameter logic [23:0] RD_MIN_ADDR   = 24'd0,
  parameter logic [23:0] RD_MAX_ADDR   = 24'd768000,
  parameter logic [10:0] RD_FIFO_DEPTH = 11'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [10:0]       wr_fifo_level,
  output logic              wr_fifo_rd_en,
  input  logic [DATA_W-1:0] wr_fifo_dout,
  input  logic [10:0]       rd_fifo_level,
  output logic              rd_fifo_wr_en,
  output logic [DATA_W-1:0] rd_fifo_din,
  input  logic              rd_enable,
  input  logic              wr_load,
  input  logic              rd_load,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_ack,
  output logic [23:0]       sdram_wr_addr,
  output logic [9:0]        sdram_wr_burst,
  output logic [DATA_W-1:0] sdram_din,
  output logic              sdram_rd_req,
  input  logic              sdram_rd_ack,
  output logic [23:0]       sdram_rd_addr,
  output logic [9:0]        sdram_rd_burst,
  input  logic [DATA_W-1:0] sdram_dout,
  output logic              burst_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_WR_DONE = 3'd3;
  localparam logic [2:0] S_RD_REQ  = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_RD_DONE = 3'd6;

  logic [2:0]        state;
  logic [23:0]       wr_ptr, rd_ptr;
  logic [10:0]       wr_cnt, rd_cnt;
  logic              wr_load_pend, rd_load_pend;
  logic              last_rd;
  logic              wr_req_q, rd_req_q;
  logic              rd_push_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              err_q;

  logic              wr_active, rd_active, wr_busy, rd_busy;
  logic              wr_ok, rd_ok, pick_wr, pick_rd;
  logic [11:0]       rd_space;
  logic [24:0]       wr_sum, wr_end, rd_sum, rd_end;
  logic [23:0]       wr_adv, rd_adv;

  always_comb begin
    wr_active = (state == S_WR_REQ) || (state == S_WR_DATA);
    rd_active = (state == S_RD_REQ) || (state == S_RD_DATA);
    wr_busy   = wr_active || (state == S_WR_DONE);
    rd_busy   = rd_active || (state == S_RD_DONE);

    wr_ok    = wr_fifo_level >= {1'b0, WR_BURST};
    rd_space = {1'b0, RD_FIFO_DEPTH} - {1'b0, rd_fifo_level};
    rd_ok    = rd_enable && !rd_space[11] && (rd_space[10:0] >= {1'b0, RD_BURST});
    // On a tie, serve whichever side was not served last.
    pick_wr  = wr_ok && (!rd_ok || last_rd);
    pick_rd  = rd_ok && (!wr_ok || !last_rd);

    // Wrap early so a burst never straddles the end of the window.
    wr_sum = {1'b0, wr_ptr} + {15'd0, WR_BURST};
    wr_end = wr_sum + {15'd0, WR_BURST};
    wr_adv = (wr_end > {1'b0, WR_MAX_ADDR}) ? WR_MIN_ADDR : wr_sum[23:0];
    rd_sum = {1'b0, rd_ptr} + {15'd0, RD_BURST};
    rd_end = rd_sum + {15'd0, RD_BURST};
    rd_adv = (rd_end > {1'b0, RD_MAX_ADDR}) ? RD_MIN_ADDR : rd_sum[23:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= WR_MIN_ADDR;
      rd_ptr       <= RD_MIN_ADDR;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      wr_load_pend <= 1'b0;
      rd_load_pend <= 1'b0;
      last_rd      <= 1'b1;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_push_q    <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      rd_push_q <= rd_active && sdram_rd_ack;
      if (rd_active && sdram_rd_ack)
        rd_data_q <= sdram_dout;

      if (wr_load && !wr_busy)
        wr_ptr <= WR_MIN_ADDR;
      else if (wr_load)
        wr_load_pend <= 1'b1;
      if (rd_load && !rd_busy)
        rd_ptr <= RD_MIN_ADDR;
      else if (rd_load)
        rd_load_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sdram_init_done && pick_wr) begin
            state    <= S_WR_REQ;
            wr_req_q <= 1'b1;
            wr_cnt   <= '0;
          end else if (sdram_init_done && pick_rd) begin
            state    <= S_RD_REQ;
            rd_req_q <= 1'b1;
            rd_cnt   <= '0;
          end
        end
        S_WR_REQ: begin
          if (sdram_wr_ack) begin
            wr_req_q <= 1'b0;
            wr_cnt   <= 11'd1;
            state    <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (sdram_wr_ack) wr_cnt <= wr_cnt + 11'd1;
          else              state  <= S_WR_DONE;
        end
        S_WR_DONE: begin
          if (wr_cnt != {1'b0, WR_BURST}) err_q <= 1'b1;
          wr_ptr       <= (wr_load || wr_load_pend) ? WR_MIN_ADDR : wr_adv;
          wr_load_pend <= 1'b0;
          last_rd      <= 1'b0;
          state        <= S_IDLE;
        end
        S_RD_REQ: begin
          if (sdram_rd_ack) begin
            rd_req_q <= 1'b0;
            rd_cnt   <= 11'd1;
            state    <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (sdram_rd_ack) rd_cnt <= rd_cnt + 11'd1;
          else              state  <= S_RD_DONE;
        end
        S_RD_DONE: begin
          if (rd_cnt != {1'b0, RD_BURST}) err_q <= 1'b1;
          rd_ptr       <= (rd_load || rd_load_pend) ? RD_MIN_ADDR : rd_adv;
          rd_load_pend <= 1'b0;
          last_rd      <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wr_fifo_rd_en  = wr_active && sdram_wr_ack;
  assign rd_fifo_wr_en  = rd_push_q;
  assign rd_fifo_din    = rd_data_q;
  assign sdram_wr_req   = wr_req_q;
  assign sdram_wr_addr  = wr_ptr;
  assign sdram_wr_burst = WR_BURST;
  assign sdram_din      = wr_fifo_dout;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_rd_addr  = rd_ptr;
  assign sdram_rd_burst = RD_BURST;
  assign burst_err      = err_q;

endmodule

// File: tb/tb_sdram_burst_master.sv
// Directed bench for sdram_burst_master; address windows shrunk to 768 words so wrap is reachable.
module tb_sdram_burst_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done;
  logic [10:0] wr_fifo_level;
  logic        wr_fifo_rd_en;
  logic [15:0] wr_fifo_dout;
  logic [10:0] rd_fifo_level;
  logic        rd_fifo_wr_en;
  logic [15:0] rd_fifo_din;
  logic        rd_enable;
  logic        wr_load;
  logic        rd_load;
  logic        sdram_wr_req;
  logic        sdram_wr_ack;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic [15:0] sdram_din;
  logic        sdram_rd_req;
  logic        sdram_rd_ack;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;
  logic [15:0] sdram_dout;
  logic        burst_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_burst_master #(
    .DATA_W(16), .WR_BURST(10'd256), .RD_BURST(10'd256),
    .WR_MIN_ADDR(24'd0), .WR_MAX_ADDR(24'd768),
    .RD_MIN_ADDR(24'd0), .RD_MAX_ADDR(24'd768),
    .RD_FIFO_DEPTH(11'd1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .wr_fifo_level(wr_fifo_level), .wr_fifo_rd_en(wr_fifo_rd_en), .wr_fifo_dout(wr_fifo_dout),
    .rd_fifo_level(rd_fifo_level), .rd_fifo_wr_en(rd_fifo_wr_en), .rd_fifo_din(rd_fifo_din),
    .rd_enable(rd_enable), .wr_load(wr_load), .rd_load(rd_load),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack), .sdram_wr_addr(sdram_wr_addr),
    .sdram_wr_burst(sdram_wr_burst), .sdram_din(sdram_din),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack), .sdram_rd_addr(sdram_rd_addr),
    .sdram_rd_burst(sdram_rd_burst), .sdram_dout(sdram_dout), .burst_err(burst_err)
  );

  // Controller model for one write burst; leaves both FIFOs ineligible from the first beat on.
  task automatic wr_burst(input int beats, output bit got_req, output logic [23:0] addr,
                          output bit req_dropped, output int pops, output int din_bad);
    got_req = 0; addr = '0; req_dropped = 0; pops = 0; din_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sdram_wr_req === 1'b1) begin got_req = 1; break; end
    end
    if (!got_req) return;
    addr = sdram_wr_addr;
    repeat (2) @(negedge clk);
    for (int b = 0; b < beats; b++) begin
      if (b == 1) req_dropped = (sdram_wr_req === 1'b0);
      sdram_wr_ack  = 1'b1;
      wr_fifo_dout  = 16'(32'hA000 + b);
      wr_fifo_level = '0;
      rd_fifo_level = 11'd1024;
      #1;
      if (wr_fifo_rd_en === 1'b1) pops++;
      if (sdram_din !== wr_fifo_dout) din_bad++;
      @(negedge clk);
    end
    sdram_wr_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Controller model for one read burst, checking the one-cycle push lag; optional rd_load pulse.
  task automatic rd_burst(input int beats, input int load_at, output bit got_req,
                          output logic [23:0] addr, output bit req_dropped,
                          output int pushes, output int lag_bad);
    bit          prev_v;
    logic [15:0] prev_d;
    got_req = 0; addr = '0; req_dropped = 0; pushes = 0; lag_bad = 0;
    prev_v = 0; prev_d = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sdram_rd_req === 1'b1) begin got_req = 1; break; end
    end
    if (!got_req) return;
    addr = sdram_rd_addr;
    repeat (2) @(negedge clk);
    for (int b = 0; b <= beats; b++) begin
      if (b == 1) req_dropped = (sdram_rd_req === 1'b0);
      if (rd_fifo_wr_en === 1'b1) begin
        pushes++;
        if (!prev_v || rd_fifo_din !== prev_d) lag_bad++;
      end else if (prev_v) lag_bad++;
      rd_load = (b == load_at);
      if (b < beats) begin
        sdram_rd_ack  = 1'b1;
        sdram_dout    = 16'(32'h5000 + b * 3);
        prev_v        = 1;
        prev_d        = sdram_dout;
        wr_fifo_level = '0;
        rd_fifo_level = 11'd1024;
      end else begin
        sdram_rd_ack = 1'b0;
        prev_v       = 0;
      end
      if (b == 0)     begin #1; if (rd_fifo_wr_en !== 1'b0) lag_bad++; end
      if (b == beats) begin #1; if (rd_fifo_wr_en !== 1'b1) lag_bad++; end
      @(negedge clk);
    end
    rd_load = 1'b0;
    if (rd_fifo_wr_en !== 1'b0) lag_bad++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sdram_init_done = 1'b0; wr_fifo_level = '0; wr_fifo_dout = '0;
    rd_fifo_level = 11'd1024; rd_enable = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_dout = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({sdram_wr_req, sdram_rd_req, wr_fifo_rd_en, rd_fifo_wr_en, burst_err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000",
        {sdram_wr_req, sdram_rd_req, wr_fifo_rd_en, rd_fifo_wr_en, burst_err});
    end
    tests++;
    if (sdram_wr_addr !== 24'd0 || sdram_rd_addr !== 24'd0 || rd_fifo_din !== 16'd0) begin
      fails++; $display("FAIL reset_regs: wr_addr %0d rd_addr %0d din %h want 0 0 0",
        sdram_wr_addr, sdram_rd_addr, rd_fifo_din);
    end
    tests++;
    if (sdram_wr_burst !== 10'd256 || sdram_rd_burst !== 10'd256) begin
      fails++; $display("FAIL burst_len: wr %0d rd %0d want 256 256", sdram_wr_burst, sdram_rd_burst);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init_gate;
    bit g, d; logic [23:0] a; int p, db, seen;
    wr_fifo_level = 11'd600;
    seen = 0;
    repeat (100) begin @(negedge clk); if (sdram_wr_req !== 1'b0) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL init_gate: req seen %0d cycles want 0", seen); end
    sdram_init_done = 1'b1;
    #1;
    tests++;
    if (sdram_wr_req !== 1'b0) begin fails++; $display("FAIL req_latency_early: got %b want 0", sdram_wr_req); end
    @(negedge clk);
    tests++;
    if (sdram_wr_req !== 1'b1) begin fails++; $display("FAIL req_latency: got %b want 1", sdram_wr_req); end
    wr_burst(256, g, a, d, p, db);
    tests++;
    if (!g || a !== 24'd0 || !d) begin
      fails++; $display("FAIL wr_req_seq: got_req %0d addr %0d dropped %0d want 1 0 1", g, a, d);
    end
    tests++;
    if (p != 256 || db != 0) begin fails++; $display("FAIL wr_pops: pops %0d din_bad %0d want 256 0", p, db); end
    tests++;
    if (sdram_wr_addr !== 24'd256 || burst_err !== 1'b0) begin
      fails++; $display("FAIL wr_advance: addr %0d err %b want 256 0", sdram_wr_addr, burst_err);
    end
  endtask

  task automatic test_levels;
    bit g, d; logic [23:0] a; int p, lb, seen;
    wr_fifo_level = 11'd255;
    seen = 0;
    repeat (20) begin @(negedge clk); if (sdram_wr_req !== 1'b0) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL wr_level_255: req cycles %0d want 0", seen); end
    wr_fifo_level = 11'd256;
    wr_burst(256, g, a, d, p, lb);
    tests++;
    if (!g || a !== 24'd256 || p != 256 || sdram_wr_addr !== 24'd512) begin
      fails++; $display("FAIL wr_level_256: req %0d addr %0d pops %0d next %0d want 1 256 256 512",
        g, a, p, sdram_wr_addr);
    end
    rd_enable = 1'b1;
    rd_fifo_level = 11'd769;
    seen = 0;
    repeat (20) begin @(negedge clk); if (sdram_rd_req !== 1'b0) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL rd_space_255: req cycles %0d want 0", seen); end
    rd_fifo_level = 11'd768;
    rd_burst(256, -1, g, a, d, p, lb);
    tests++;
    if (!g || a !== 24'd0 || !d) begin
      fails++; $display("FAIL rd_req_seq: got_req %0d addr %0d dropped %0d want 1 0 1", g, a, d);
    end
    tests++;
    if (p != 256 || lb != 0) begin fails++; $display("FAIL rd_pushes: pushes %0d lag_bad %0d want 256 0", p, lb); end
    tests++;
    if (sdram_rd_addr !== 24'd256) begin fails++; $display("FAIL rd_advance: addr %0d want 256", sdram_rd_addr); end
  endtask

  task automatic test_arbitration;
    logic [23:0] exp_addr [4];
    bit g, d; logic [23:0] a; int p, x; bit is_wr, found;
    exp_addr[0] = 24'd512; exp_addr[1] = 24'd256; exp_addr[2] = 24'd0; exp_addr[3] = 24'd512;
    for (int k = 0; k < 4; k++) begin
      wr_fifo_level = 11'd600; rd_enable = 1'b1; rd_fifo_level = 11'd0;
      found = 0; is_wr = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (sdram_wr_req === 1'b1 || sdram_rd_req === 1'b1) begin
          found = 1; is_wr = (sdram_wr_req === 1'b1); break;
        end
      end
      tests++;
      if (!found || is_wr != (k % 2 == 0)) begin
        fails++; $display("FAIL arb_order[%0d]: found %0d write %0d want 1 %0d", k, found, is_wr, k % 2 == 0);
      end
      if (is_wr) wr_burst(256, g, a, d, p, x);
      else       rd_burst(256, -1, g, a, d, p, x);
      tests++;
      if (!g || a !== exp_addr[k]) begin
        fails++; $display("FAIL arb_addr[%0d]: req %0d addr %0d want 1 %0d", k, g, a, exp_addr[k]);
      end
    end
    tests++;
    if (sdram_wr_addr !== 24'd256 || sdram_rd_addr !== 24'd0) begin
      fails++; $display("FAIL wrap_ptrs: wr %0d rd %0d want 256 0", sdram_wr_addr, sdram_rd_addr);
    end
  endtask

  task automatic test_loads;
    bit g, d; logic [23:0] a; int p, lb;
    rd_enable = 1'b1; rd_fifo_level = 11'd0; wr_fifo_level = 11'd0;
    rd_burst(256, -1, g, a, d, p, lb);
    tests++;
    if (!g || a !== 24'd0 || sdram_rd_addr !== 24'd256) begin
      fails++; $display("FAIL rd_prelim: req %0d addr %0d next %0d want 1 0 256", g, a, sdram_rd_addr);
    end
    rd_fifo_level = 11'd0;
    rd_burst(256, 100, g, a, d, p, lb);
    tests++;
    if (!g || a !== 24'd256 || p != 256 || lb != 0) begin
      fails++; $display("FAIL rd_load_burst: req %0d addr %0d pushes %0d lag_bad %0d want 1 256 256 0",
        g, a, p, lb);
    end
    tests++;
    if (sdram_rd_addr !== 24'd0) begin fails++; $display("FAIL rd_load_ptr: addr %0d want 0", sdram_rd_addr); end
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    tests++;
    if (sdram_wr_addr !== 24'd0) begin fails++; $display("FAIL wr_load_idle: addr %0d want 0", sdram_wr_addr); end
  endtask

  task automatic test_foreign_ack;
    int bad;
    bad = 0;
    wr_fifo_level = '0; rd_fifo_level = 11'd1024;
    @(negedge clk);
    sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b1; sdram_dout = 16'hDEAD;
    #1; if (wr_fifo_rd_en !== 1'b0) bad++;
    @(negedge clk);
    if (rd_fifo_wr_en !== 1'b0) bad++;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || rd_fifo_din === 16'hDEAD) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL foreign_ack: %0d bad observations want 0", bad); end
  endtask

  task automatic test_burst_err;
    bit g, d; logic [23:0] a; int p, x;
    wr_fifo_level = 11'd600;
    wr_burst(255, g, a, d, p, x);
    tests++;
    if (!g || a !== 24'd0 || p != 255) begin
      fails++; $display("FAIL short_burst: req %0d addr %0d pops %0d want 1 0 255", g, a, p);
    end
    tests++;
    if (burst_err !== 1'b1 || sdram_wr_addr !== 24'd256) begin
      fails++; $display("FAIL burst_err_set: err %b addr %0d want 1 256", burst_err, sdram_wr_addr);
    end
    rd_enable = 1'b1; rd_fifo_level = 11'd0;
    rd_burst(256, -1, g, a, d, p, x);
    tests++;
    if (!g || burst_err !== 1'b1 || sdram_rd_addr !== 24'd256) begin
      fails++; $display("FAIL burst_err_sticky: req %0d err %b rd_addr %0d want 1 1 256",
        g, burst_err, sdram_rd_addr);
    end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_levels();
    test_arbitration();
    test_loads();
    test_foreign_ack();
    test_burst_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
